// File: rtl/bram_burst_rd.sv
// ---------------------------------------------------------------------------
// bram_burst_rd
//
// Burst read controller in front of an 18-bit x 4096 block RAM. It owns the
// RAM port, accepts a (base, length) request, streams the addressed words
// out through a 2-entry {last, data} FIFO on a valid/ready interface, and
// gives a host write port priority access to the RAM in every state.
//
// Ports
//   CLK, RST                     clock, synchronous active-high reset
//   REQ_VALID/REQ_READY          burst request handshake (ready == IDLE)
//   REQ_BASE [AW-1:0]            first word address
//   REQ_LEN  [AW:0]              number of words (0 = empty burst)
//   WR_VALID/WR_ADDR/WR_DATA     host write request, never stalled
//   WR_READY                     high whenever RST is low
//   OUT_VALID/OUT_READY          output beat handshake
//   OUT_DATA [DW-1:0], OUT_LAST  FIFO head word and its end-of-burst flag
//   DONE                         one-cycle pulse after a burst completes
//   BRAM_EN/READ/WRITE/ADDR/DIN  RAM controls
//   DOUT [DW-1:0]                RAM read data, combinational in ADDR/READ
// ---------------------------------------------------------------------------
module bram_burst_rd #(
    parameter int DW = 18,
    parameter int AW = 12
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [AW-1:0] REQ_BASE,
    input  logic [AW:0]   REQ_LEN,

    input  logic          WR_VALID,
    input  logic [AW-1:0] WR_ADDR,
    input  logic [DW-1:0] WR_DATA,
    output logic          WR_READY,

    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] OUT_DATA,
    output logic          OUT_LAST,
    output logic          DONE,

    output logic          BRAM_EN,
    output logic          READ,
    output logic          WRITE,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] DIN,
    input  logic [DW-1:0] DOUT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_reg;
    logic [AW-1:0] rd_addr_reg;
    logic [AW:0]   rd_left_reg;
    logic          done_reg;

    // Output FIFO: two {last, data} entries, one-bit pointers plus occupancy.
    logic [DW:0]   fifo_mem [2];
    logic [1:0]    count_reg;
    logic          rd_ptr_reg;
    logic          wr_ptr_reg;

    logic          active;
    logic          out_valid;
    logic [DW:0]   head;
    logic          pop;
    logic          fifo_room;
    logic          grant_wr;
    logic          issue_rd;
    logic          push_last;

    // -----------------------------------------------------------------------
    // Combinational arbitration and FIFO status
    // -----------------------------------------------------------------------
    assign active    = !RST;
    assign out_valid = (count_reg != 2'd0);
    assign head      = fifo_mem[rd_ptr_reg];
    assign pop       = out_valid && OUT_READY;

    // A full FIFO can still accept a word in a cycle where its head is
    // popped, which keeps throughput at one beat per cycle.
    assign fifo_room = (count_reg != 2'd2) || pop;

    // Host writes always win the RAM port; a read only issues in RUN on a
    // cycle without a host write and with room downstream.
    assign grant_wr  = active && WR_VALID;
    assign issue_rd  = active && (state_reg == ST_RUN) && !WR_VALID && fifo_room;
    assign push_last = (rd_left_reg == {{AW{1'b0}}, 1'b1});

    // -----------------------------------------------------------------------
    // RAM port. DOUT is combinational, so the word read this cycle is
    // captured into the FIFO at the coming edge.
    // -----------------------------------------------------------------------
    assign BRAM_EN = grant_wr || issue_rd;
    assign WRITE   = grant_wr;
    assign READ    = issue_rd;
    assign ADDR    = grant_wr ? WR_ADDR : rd_addr_reg;
    assign DIN     = grant_wr ? WR_DATA : '0;

    assign WR_READY  = active;
    assign REQ_READY = (state_reg == ST_IDLE);
    assign OUT_VALID = out_valid;
    assign OUT_DATA  = head[DW-1:0];
    assign OUT_LAST  = out_valid && head[DW];
    assign DONE      = done_reg;

    // -----------------------------------------------------------------------
    // Control FSM, burst counters and FIFO pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            rd_addr_reg <= '0;
            rd_left_reg <= '0;
            done_reg    <= 1'b0;
            count_reg   <= 2'd0;
            rd_ptr_reg  <= 1'b0;
            wr_ptr_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (REQ_VALID) begin
                        rd_addr_reg <= REQ_BASE;
                        rd_left_reg <= REQ_LEN;
                        // An empty burst completes without leaving IDLE.
                        if (REQ_LEN == '0) begin
                            done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (issue_rd) begin
                        // Address wraps naturally at 2^AW.
                        rd_addr_reg <= rd_addr_reg + 1'b1;
                        rd_left_reg <= rd_left_reg - 1'b1;
                        if (push_last) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    // The burst ends when its last beat is handed over.
                    if (pop && head[DW]) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (issue_rd) begin
                wr_ptr_reg <= !wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= !rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, issue_rd} - {1'b0, pop};
        end
    end

    // FIFO storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge CLK) begin
        if (issue_rd) begin
            fifo_mem[wr_ptr_reg] <= {push_last, DOUT};
        end
    end

endmodule

// File: tb/tb_bram_burst_rd.sv
// ---------------------------------------------------------------------------
// tb_bram_burst_rd
//
// Testbench for bram_burst_rd. It models the external RAM, drives requests,
// host writes and OUT_READY from one stimulus thread, and keeps a reference
// memory image. Each accepted request pushes its expected beats into a
// queue; an independent monitor pops and compares on every output handshake
// and checks port-level rules every cycle.
// ---------------------------------------------------------------------------
module tb_bram_burst_rd;

    localparam int DW = 18;
    localparam int AW = 12;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_base = '0;
    logic [AW:0]   req_len = '0;
    logic          wr_valid = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          bram_en;
    logic          read;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;

    bram_burst_rd #(.DW(DW), .AW(AW)) dut (
        .CLK(clk), .RST(rst),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_BASE(req_base), .REQ_LEN(req_len),
        .WR_VALID(wr_valid), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .WR_READY(wr_ready),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_DATA(out_data), .OUT_LAST(out_last), .DONE(done),
        .BRAM_EN(bram_en), .READ(read), .WRITE(write),
        .ADDR(addr), .DIN(din), .DOUT(dout)
    );

    always #5 clk = !clk;

    // External RAM: synchronous write, combinational read.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (bram_en && write) ram[addr] <= din;
    end
    assign dout = (bram_en && read) ? ram[addr] : '0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            due;
    } beat_t;

    beat_t         exp_q[$];
    int            done_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    int            beats_seen = 0;
    int            inflight = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor: samples on the falling edge, away from the active edge.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        automatic logic  hs;
        automatic logic  exp_done;
        automatic beat_t e;

        exp_done = 1'b0;
        if (done_q.size() > 0 && done_q[0] == cyc) begin
            exp_done = 1'b1;
            void'(done_q.pop_front());
        end
        if (done || exp_done) check("done_pulse", 32'(done), 32'(exp_done));

        if (rst) begin
            check("wr_ready_in_reset", 32'(wr_ready), 32'd0);
            check("bram_en_in_reset", 32'(bram_en), 32'd0);
            inflight = 0;
        end else begin
            hs = out_valid && out_ready;
            check("wr_ready", 32'(wr_ready), 32'd1);
            check("read_write_exclusive", 32'(read && write), 32'd0);
            check("bram_en", 32'(bram_en), 32'(read || write));
            check("out_valid_vs_occupancy", 32'(out_valid), 32'(inflight > 0));
            if (wr_valid) begin
                check("write_granted", 32'(write), 32'd1);
                check("write_addr", 32'(addr), 32'(wr_addr));
                check("write_data", 32'(din), 32'(wr_data));
            end
            if (read) check("read_needs_room", 32'(inflight < 2 || hs), 32'd1);
            if (out_valid && exp_q.size() == 0) check("unexpected_beat", 32'(out_valid), 32'd0);

            if (hs && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e.data));
                check("beat_last", 32'(out_last), 32'(e.last));
                if (e.due >= 0) check("beat_cycle", 32'(cyc), 32'(e.due));
                if (e.last) done_q.push_back(cyc + 1);
            end
            if (hs) beats_seen++;
            inflight = inflight + int'(read) - int'(hs);
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        ref_mem[a] = d;
        step();
        wr_valid = 1'b0;
    endtask

    // Issue a request; returns in the cycle right after acceptance. When t0
    // is positive, beat i must be handed over in cycle accept + t0 + i.
    task automatic do_req(input logic [AW-1:0] base, input int len, input int t0);
        int guard;
        int a;
        guard = 0;
        while (!req_ready && guard < 1000) begin
            step();
            guard++;
        end
        if (!req_ready) check("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_base  = base;
        req_len   = (AW+1)'(len);
        step();
        req_valid = 1'b0;
        a = cyc;
        for (int i = 0; i < len; i++) begin
            beat_t e;
            e.data = ref_mem[(int'(base) + i) % DEPTH];
            e.last = (i == len - 1);
            e.due  = (t0 > 0) ? (a + t0 + i) : -1;
            exp_q.push_back(e);
        end
        if (len == 0) done_q.push_back(a);
    endtask

    // Run until the burst is fully delivered and DONE has been seen.
    // mode 0: OUT_READY high, 1: pattern 1,0,0 repeating, 2: random.
    // rand_wr adds random host writes into the upper half of memory.
    task automatic wait_idle(input int mode, input bit rand_wr);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && done_q.size() == 0 && req_ready) && n < 20000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (n % 3 == 0);
                default: out_ready = $urandom_range(0, 1) == 1;
            endcase
            if (rand_wr && $urandom_range(0, 3) == 0) begin
                wr_valid = 1'b1;
                wr_addr  = AW'(12'h800 | $urandom_range(0, 12'h7FF));
                wr_data  = DW'($urandom);
                ref_mem[wr_addr] = wr_data;
            end else begin
                wr_valid = 1'b0;
            end
            step();
            n++;
        end
        wr_valid = 1'b0;
        if (n >= 20000) begin
            check("burst_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            done_q.delete();
        end
    endtask

    // -----------------------------------------------------------------------
    // Main stimulus
    // -----------------------------------------------------------------------
    initial begin
        int guard;
        int start;

        // Reset state
        step();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Fill the whole RAM with random words through the host port.
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1;
            wr_addr  = AW'(i);
            wr_data  = DW'($urandom);
            ref_mem[i] = wr_data;
            step();
        end
        wr_valid = 1'b0;

        // Basic burst: beats on consecutive cycles from accept+1.
        for (int i = 0; i < 4; i++) host_write(AW'(12'h010 + i), DW'(i + 1));
        out_ready = 1'b1;
        do_req(12'h010, 4, 1);
        wait_idle(0, 1'b0);

        // Address wrap 0xFFF -> 0x000.
        host_write(12'hFFE, 18'h0AAAA);
        host_write(12'hFFF, 18'h0BBBB);
        host_write(12'h000, 18'h0CCCC);
        host_write(12'h001, 18'h0DDDD);
        do_req(12'hFFE, 4, 1);
        wait_idle(0, 1'b0);

        // Backpressure with OUT_READY pattern 1,0,0,...
        do_req(12'h040, 8, 0);
        wait_idle(1, 1'b0);

        // Host write steals the first read slot; later read sees new data.
        out_ready = 1'b1;
        ref_mem[12'h104] = 18'h3FFFF;
        do_req(12'h100, 6, 2);
        wr_valid = 1'b1;
        wr_addr  = 12'h104;
        wr_data  = 18'h3FFFF;
        step();
        wr_valid = 1'b0;
        wait_idle(0, 1'b0);

        // Empty burst.
        do_req(12'h123, 0, 0);
        check("len0_req_ready", 32'(req_ready), 32'd1);
        wait_idle(0, 1'b0);
        check("len0_req_ready_after", 32'(req_ready), 32'd1);

        // Reset mid-burst after two beats; write in reset cycle is dropped.
        out_ready = 1'b1;
        start = beats_seen;
        do_req(12'h200, 8, 0);
        guard = 0;
        while (beats_seen < start + 2 && guard < 100) begin
            step();
            guard++;
        end
        check("beats_before_reset", 32'(beats_seen >= start + 2), 32'd1);
        rst      = 1'b1;
        wr_valid = 1'b1;
        wr_addr  = 12'h000;
        wr_data  = ~ref_mem[0];
        exp_q.delete();
        done_q.delete();
        step();
        rst      = 1'b0;
        wr_valid = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        do_req(12'h000, 1, 1);
        wait_idle(0, 1'b0);

        // Randomized bursts with random backpressure and unrelated writes.
        for (int k = 0; k < 30; k++) begin
            do_req(AW'($urandom_range(0, 12'h6FF)), $urandom_range(0, 48), 0);
            wait_idle($urandom_range(0, 2), 1'b1);
        end

        // Long burst covering the whole RAM and re-reading wrapped words.
        out_ready = 1'b1;
        do_req(12'h800, 4100, 1);
        wait_idle(0, 1'b0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_burst_rd.md
# bram_burst_rd

Burst read controller that sits directly upstream of the 18-bit × 4096 block RAM and owns its port. It accepts a (base, length) request, streams the addressed words out over a valid/ready interface through a 2-entry output FIFO, and gives a host write port priority access to the RAM at any time. Its consumers are the BCP engine stages that walk clause and watch lists stored in the RAM.

## Interface
- DW, 18, data width; matches RAM word.
- AW, 12, address width; RAM depth 2^AW.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ_VALID  in  1  burst request valid.
- REQ_READY  out  1  request accepted when high with REQ_VALID; equals (state==IDLE).
- REQ_BASE  in  AW  first word address.
- REQ_LEN  in  AW+1  number of words, 0..2^(AW+1)-1.
- WR_VALID  in  1  host write request.
- WR_ADDR  in  AW  host write address.
- WR_DATA  in  DW  host write data.
- WR_READY  out  1  high whenever RST is low; writes are never stalled.
- OUT_VALID  out  1  OUT_DATA valid (FIFO non-empty).
- OUT_READY  in  1  consumer accepts beat.
- OUT_DATA  out  DW  FIFO head word.
- OUT_LAST  out  1  head word is last of burst.
- DONE  out  1  one-cycle pulse, burst complete.
- BRAM_EN, READ, WRITE  out  1 each  RAM controls.
- ADDR  out  AW  RAM address.
- DIN  out  DW  RAM write data.
- DOUT  in  DW  RAM read data (combinational in ADDR, READ, BRAM_EN).

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: REQ_VALID&REQ_READY latches rd_addr=REQ_BASE, rd_left=REQ_LEN. If REQ_LEN==0, stay in IDLE, pulse DONE next cycle, emit no beats. Otherwise go to RUN.
- RUN, per cycle:
  - If WR_VALID: BRAM_EN=1, WRITE=1, READ=0, ADDR=WR_ADDR, DIN=WR_DATA. No read issues this cycle.
  - Else, if the FIFO can take a word (count<2, or count==2 with a pop this cycle): BRAM_EN=1, READ=1, ADDR=rd_addr. DOUT is pushed with last=(rd_left==1), rd_addr increments modulo 2^AW, and rd_left decrements.
  - Otherwise all RAM controls are 0.
  - Leave RUN for DRAIN when the final read issues (rd_left 1→0).
- DRAIN: no reads issue; host writes are still served. The state returns to IDLE on the handshake of the OUT_LAST beat.
- Address wrap: 0xFFF→0x000. Lengths above 4096 re-read wrapped addresses.
- Host write and read to the same address: the write takes the cycle, and the later read returns the new data.
- FIFO: 2 entries of {last, data}. Pop on OUT_VALID&OUT_READY. Push and pop in the same cycle are allowed when full.
- OUT_VALID must never depend combinationally on OUT_READY.

## Timing
- Reset values: state=IDLE, FIFO empty, OUT_VALID=0, OUT_LAST=0, DONE=0, rd_left=0.
- While RST is high: WR_READY=0, BRAM_EN=READ=WRITE=0, and WR_VALID is ignored. REQ_READY is 1 from the first cycle after RST deasserts.
- Request accepted at edge N:
  - First read issues in cycle N+1, provided WR_VALID is low.
  - OUT_VALID rises in cycle N+2.
- Throughput is 1 beat per cycle when OUT_READY is held high and no writes occur. Each granted host write costs exactly one read slot.
- DONE is registered: it is high in the cycle after the OUT_LAST handshake, and REQ_READY is already 1 in that cycle. A new request accepted in the DONE cycle is legal.
- For LEN=0 accepted at edge N: DONE is high in cycle N+1.
- RST mid-burst: at the next edge the FIFO is flushed, the state goes to IDLE, and no DONE is produced. A host write presented in the reset cycle is dropped.
- Backpressure: with OUT_READY low and the FIFO full, READ stays 0 and rd_addr/rd_left hold.

## Test plan
- Preload mem[0x010..0x013]=0x00001..0x00004 via host writes. Request BASE=0x010, LEN=4, OUT_READY=1 → beats 1,2,3,4 on consecutive cycles starting N+2, OUT_LAST only on the 4th beat, DONE one cycle later.
- BASE=0xFFE, LEN=4 with mem[0xFFE,0xFFF,0x000,0x001]=A,B,C,D → beats A,B,C,D in order (wrap), then DONE.
- LEN=8 with OUT_READY toggling 1,0,0,1,… → every word is delivered exactly once and in order, with no READ while the FIFO is full and not popping.
- During a LEN=6 burst from 0x100, host-write 0x3FFFF to 0x104 before that read issues → 5th beat = 0x3FFFF, burst takes one extra cycle, WRITE and READ are never high together.
- LEN=0 request → no OUT_VALID, DONE high the next cycle, REQ_READY stays 1.
- Assert RST after 2 of 8 beats → OUT_VALID=0 and REQ_READY=1 after reset, no DONE, and a following request with BASE=0x000, LEN=1 completes normally.
